// File: rtl/dsp_config_chain_loader_if.sv
// Configuration word stream into the DSP chain loader (valid/ready).
interface dsp_config_chain_loader_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dsp_config_chain_loader.sv
// Serializes configuration words LSB-first onto a DSP_proposed_MF2 config chain.
// Optional CRC-16-CCITT check word after the chain: define CFG_LOADER_CRC_EN.
module dsp_config_chain_loader #(
    parameter int CHAIN_LENGTH = 96,
    parameter int WORD_WIDTH   = 16,
    localparam int CNT_W       = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    dsp_config_chain_loader_if.slave s,
    output logic                     configuration_input,
    output logic                     configuration_enable,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         bits_shifted,
    output logic                     crc_error
);
    localparam int WB_W = $clog2(WORD_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
`ifdef CFG_LOADER_CRC_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t                state, state_n;
    logic [WORD_WIDTH-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]      bits_n;
    logic [WB_W-1:0]       word_bits, word_bits_n;
    logic                  cfg_in_n, cfg_en_n;
    logic [31:0]           remain;
`ifdef CFG_LOADER_CRC_EN
    logic [15:0]           crc, crc_n;
    logic                  crc_err_n;
    logic                  fb;
`endif

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bits_n      = bits_shifted;
        word_bits_n = word_bits;
        cfg_in_n    = configuration_input;
        cfg_en_n    = 1'b0;
        remain      = 32'(CHAIN_LENGTH) - 32'(bits_shifted);
`ifdef CFG_LOADER_CRC_EN
        crc_n       = crc;
        crc_err_n   = crc_error;
        fb          = crc[15] ^ shreg[0];
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = LOAD;
                    bits_n  = '0;
`ifdef CFG_LOADER_CRC_EN
                    crc_n     = '1;
                    crc_err_n = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (s.s_valid) begin
                    shreg_n = s.s_data;
                    // Last word may be partial: upper bits beyond the chain end are never shifted.
                    if (remain < 32'(WORD_WIDTH))
                        word_bits_n = WB_W'(remain);
                    else
                        word_bits_n = WB_W'(WORD_WIDTH);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                cfg_en_n    = 1'b1;
                cfg_in_n    = shreg[0];
                shreg_n     = shreg >> 1;
                word_bits_n = word_bits - WB_W'(1);
                if (bits_shifted != CNT_W'(CHAIN_LENGTH))
                    bits_n = bits_shifted + CNT_W'(1);
`ifdef CFG_LOADER_CRC_EN
                crc_n = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
`endif
                if (word_bits == WB_W'(1)) begin
                    if (bits_n == CNT_W'(CHAIN_LENGTH))
`ifdef CFG_LOADER_CRC_EN
                        state_n = CHECK;
`else
                        state_n = DONE;
`endif
                    else
                        state_n = LOAD;
                end
            end
`ifdef CFG_LOADER_CRC_EN
            CHECK: begin
                if (s.s_valid) begin
                    crc_err_n = (s.s_data[15:0] != crc);
                    state_n   = DONE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            shreg                <= '0;
            bits_shifted         <= '0;
            word_bits            <= '0;
            configuration_input  <= 1'b0;
            configuration_enable <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc                  <= '1;
            crc_error            <= 1'b0;
`endif
        end else begin
            state                <= state_n;
            shreg                <= shreg_n;
            bits_shifted         <= bits_n;
            word_bits            <= word_bits_n;
            configuration_input  <= cfg_in_n;
            configuration_enable <= cfg_en_n;
`ifdef CFG_LOADER_CRC_EN
            crc                  <= crc_n;
            crc_error            <= crc_err_n;
`endif
        end
    end

`ifdef CFG_LOADER_CRC_EN
    assign s.s_ready = (state == LOAD) || (state == CHECK);
    assign busy      = (state == LOAD) || (state == SHIFT) || (state == CHECK);
`else
    assign s.s_ready = (state == LOAD);
    assign busy      = (state == LOAD) || (state == SHIFT);
    assign crc_error = 1'b0;
`endif
    assign done = (state == DONE);

endmodule

// File: tb/tb_dsp_config_chain_loader.sv
// Directed bench for dsp_config_chain_loader: 96-bit and 40-bit chains, back-pressure, restart, reset, CRC.
module tb_dsp_config_chain_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CFG_LOADER_CRC_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    logic        reset, start, sel;
    logic [15:0] drv_data;
    logic        drv_valid;

    dsp_config_chain_loader_if #(.WORD_WIDTH(16)) if96 ();
    dsp_config_chain_loader_if #(.WORD_WIDTH(16)) if40 ();
    assign if96.s_data  = drv_data;
    assign if96.s_valid = drv_valid & ~sel;
    assign if40.s_data  = drv_data;
    assign if40.s_valid = drv_valid & sel;

    logic       in96, en96, busy96, done96, crc96;
    logic [6:0] bs96;
    logic       in40, en40, busy40, done40, crc40;
    logic [5:0] bs40;

    dsp_config_chain_loader #(.CHAIN_LENGTH(96), .WORD_WIDTH(16)) dut96 (
        .clk(clk), .reset(reset), .start(start & ~sel), .s(if96),
        .configuration_input(in96), .configuration_enable(en96),
        .busy(busy96), .done(done96), .bits_shifted(bs96), .crc_error(crc96)
    );
    dsp_config_chain_loader #(.CHAIN_LENGTH(40), .WORD_WIDTH(16)) dut40 (
        .clk(clk), .reset(reset), .start(start & sel), .s(if40),
        .configuration_input(in40), .configuration_enable(en40),
        .busy(busy40), .done(done40), .bits_shifted(bs40), .crc_error(crc40)
    );

    logic cur_ready, cur_en, cur_in, cur_busy, cur_done, cur_crc;
    int   cur_bs;
    always_comb begin
        cur_ready = sel ? if40.s_ready : if96.s_ready;
        cur_en    = sel ? en40   : en96;
        cur_in    = sel ? in40   : in96;
        cur_busy  = sel ? busy40 : busy96;
        cur_done  = sel ? done40 : done96;
        cur_crc   = sel ? crc40  : crc96;
        cur_bs    = sel ? int'(bs40) : int'(bs96);
    end

    int          checks = 0;
    int          errors = 0;
    logic [15:0] words [0:7];
    logic        rec [0:127];
    int          en_cnt, runs, done_edge, stall_en_hi, stall_bs_lo, stall_bs_hi;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc_of(input int nbits);
        logic [15:0] c;
        logic [15:0] w;
        logic        b;
        c = 16'hFFFF;
        for (int i = 0; i < nbits; i++) begin
            w = words[i / 16];
            b = w[i % 16];
            if (c[15] ^ b) c = {c[14:0], 1'b0} ^ 16'h1021;
            else           c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Values seen #1 after edge n are what edge n+1 samples, hence done_edge = cyc + 1.
    task automatic run(input bit do_start, input int start_at, input int stall_at,
                       input int stall_len, input int abort_bs, input int max_cyc);
        int widx, cyc, stall_left;
        bit hs, stalled, prev_en;
        widx = 0; cyc = 0; stall_left = stall_len; prev_en = 1'b0;
        en_cnt = 0; runs = 0; done_edge = -1;
        stall_en_hi = 0; stall_bs_lo = 9999; stall_bs_hi = -1;
        drv_data = words[0];
        drv_valid = 1'b1;
        if (do_start) begin
            start = 1'b1;
            tick;
            start = 1'b0;
        end
        while (cyc < max_cyc) begin
            stalled = 1'b0;
            drv_valid = 1'b1;
            if (stall_left > 0 && widx == stall_at && cur_ready) begin
                drv_valid = 1'b0;
                stalled = 1'b1;
                stall_left--;
            end
            hs = drv_valid && cur_ready;
            start = (start_at == cyc + 1);
            tick;
            cyc++;
            start = 1'b0;
            if (hs) begin
                widx++;
                drv_data = (widx < 8) ? words[widx] : 16'h0000;
            end
            if (cur_en) begin
                if (en_cnt < 128) rec[en_cnt] = cur_in;
                en_cnt++;
                if (!prev_en) runs++;
            end
            prev_en = cur_en;
            if (stalled) begin
                if (cur_en) stall_en_hi++;
                if (cur_bs < stall_bs_lo) stall_bs_lo = cur_bs;
                if (cur_bs > stall_bs_hi) stall_bs_hi = cur_bs;
            end
            if (abort_bs >= 0 && cur_bs == abort_bs) break;
            if (cur_done) begin
                done_edge = cyc + 1;
                break;
            end
        end
        drv_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        checks++; if ({busy96, done96, en96, in96, if96.s_ready, crc96} !== 6'b0) begin errors++; $display("FAIL reset96_flags got %b expected 000000", {busy96, done96, en96, in96, if96.s_ready, crc96}); end
        checks++; if (bs96 !== 7'd0) begin errors++; $display("FAIL reset96_bits got %0d expected 0", bs96); end
        checks++; if ({busy40, done40, en40, in40, if40.s_ready, crc40} !== 6'b0) begin errors++; $display("FAIL reset40_flags got %b expected 000000", {busy40, done40, en40, in40, if40.s_ready, crc40}); end
        checks++; if (bs40 !== 6'd0) begin errors++; $display("FAIL reset40_bits got %0d expected 0", bs40); end
    endtask

    task automatic test_full_load;
        int bad;
        for (int i = 0; i < 6; i++) words[i] = 16'hAAAA;
        words[6] = crc_of(96);
        run(1'b1, -1, -1, 0, -1, 400);
        bad = 0;
        for (int i = 0; i < 96; i++) if (rec[i] !== logic'(i % 2 == 1)) bad++;
        checks++; if (done_edge != 103 + XTRA) begin errors++; $display("FAIL full_done_edge got %0d expected %0d", done_edge, 103 + XTRA); end
        checks++; if (en_cnt != 96) begin errors++; $display("FAIL full_enable_count got %0d expected 96", en_cnt); end
        checks++; if (runs != 6) begin errors++; $display("FAIL full_enable_runs got %0d expected 6", runs); end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_pattern got %0d bad bits expected 0", bad); end
        checks++; if (cur_bs != 96) begin errors++; $display("FAIL full_bits_shifted got %0d expected 96", cur_bs); end
        checks++; if (cur_crc !== 1'b0 || cur_busy !== 1'b0) begin errors++; $display("FAIL full_crc_busy got %b%b expected 00", cur_crc, cur_busy); end
    endtask

    task automatic test_partial_word;
        int bad;
        logic [7:0] tail;
        logic exp_bit;
        tail = 8'b1100_0011;
        sel = 1'b1;
        words[0] = 16'hFFFF; words[1] = 16'h0000; words[2] = 16'hA5C3;
        words[3] = crc_of(40);
        run(1'b1, -1, -1, 0, -1, 200);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            exp_bit = (i < 16) ? 1'b1 : (i < 32) ? 1'b0 : tail[i - 32];
            if (rec[i] !== exp_bit) bad++;
        end
        checks++; if (en_cnt != 40) begin errors++; $display("FAIL partial_enable_count got %0d expected 40", en_cnt); end
        checks++; if (bad != 0) begin errors++; $display("FAIL partial_pattern got %0d bad bits expected 0", bad); end
        checks++; if (done_edge != 44 + XTRA) begin errors++; $display("FAIL partial_done_edge got %0d expected %0d", done_edge, 44 + XTRA); end
        checks++; if (cur_bs != 40 || cur_crc !== 1'b0) begin errors++; $display("FAIL partial_bits_crc got %0d/%b expected 40/0", cur_bs, cur_crc); end
        sel = 1'b0;
    endtask

    task automatic test_back_pressure;
        for (int i = 0; i < 6; i++) words[i] = 16'h5A0F ^ 16'(i);
        words[6] = crc_of(96);
        run(1'b1, -1, 2, 5, -1, 400);
        checks++; if (stall_en_hi != 0) begin errors++; $display("FAIL stall_enable got %0d high cycles expected 0", stall_en_hi); end
        checks++; if (stall_bs_lo != 32 || stall_bs_hi != 32) begin errors++; $display("FAIL stall_bits_shifted got %0d..%0d expected 32..32", stall_bs_lo, stall_bs_hi); end
        checks++; if (done_edge != 108 + XTRA) begin errors++; $display("FAIL stall_done_edge got %0d expected %0d", done_edge, 108 + XTRA); end
        checks++; if (en_cnt != 96) begin errors++; $display("FAIL stall_enable_count got %0d expected 96", en_cnt); end
    endtask

    task automatic test_start_ignored_and_restart;
        int bad;
        logic [15:0] w;
        for (int i = 0; i < 6; i++) words[i] = 16'hC3A5 + 16'(i * 16'h0101);
        words[6] = crc_of(96);
        run(1'b1, 20, -1, 0, -1, 400);
        checks++; if (done_edge != 103 + XTRA || en_cnt != 96) begin errors++; $display("FAIL start_in_shift got edge %0d en %0d expected %0d/96", done_edge, en_cnt, 103 + XTRA); end
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (done96 !== 1'b0) begin errors++; $display("FAIL restart_done got %b expected 0", done96); end
        checks++; if (bs96 !== 7'd0) begin errors++; $display("FAIL restart_bits got %0d expected 0", bs96); end
        checks++; if (if96.s_ready !== 1'b1) begin errors++; $display("FAIL restart_ready got %b expected 1", if96.s_ready); end
        run(1'b0, -1, -1, 0, -1, 400);
        bad = 0;
        for (int i = 0; i < 96; i++) begin
            w = words[i / 16];
            if (rec[i] !== w[i % 16]) bad++;
        end
        checks++; if (done_edge != 103 + XTRA || bs96 !== 7'd96) begin errors++; $display("FAIL reload_done got edge %0d bits %0d expected %0d/96", done_edge, bs96, 103 + XTRA); end
        checks++; if (bad != 0) begin errors++; $display("FAIL reload_pattern got %0d bad bits expected 0", bad); end
    endtask

    task automatic test_reset_mid_load;
        int bad;
        logic [15:0] w;
        for (int i = 0; i < 6; i++) words[i] = 16'h1234 + 16'(i * 16'h1111);
        words[6] = crc_of(96);
        run(1'b1, -1, -1, 0, 50, 400);
        checks++; if (bs96 !== 7'd50) begin errors++; $display("FAIL abort_reached got %0d expected 50", bs96); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if ({busy96, done96, en96, in96, if96.s_ready, crc96} !== 6'b0) begin errors++; $display("FAIL midreset_flags got %b expected 000000", {busy96, done96, en96, in96, if96.s_ready, crc96}); end
        checks++; if (bs96 !== 7'd0) begin errors++; $display("FAIL midreset_bits got %0d expected 0", bs96); end
        tick;
        checks++; if (busy96 !== 1'b0) begin errors++; $display("FAIL midreset_idle got busy %b expected 0", busy96); end
        run(1'b1, -1, -1, 0, -1, 400);
        bad = 0;
        for (int i = 0; i < 96; i++) begin
            w = words[i / 16];
            if (rec[i] !== w[i % 16]) bad++;
        end
        checks++; if (done_edge != 103 + XTRA || en_cnt != 96) begin errors++; $display("FAIL postreset_load got edge %0d en %0d expected %0d/96", done_edge, en_cnt, 103 + XTRA); end
        checks++; if (bad != 0) begin errors++; $display("FAIL postreset_pattern got %0d bad bits expected 0", bad); end
    endtask

`ifdef CFG_LOADER_CRC_EN
    task automatic test_crc;
        for (int i = 0; i < 6; i++) words[i] = 16'h0000;
        words[6] = crc_of(96);
        run(1'b1, -1, -1, 0, -1, 400);
        checks++; if (crc96 !== 1'b0) begin errors++; $display("FAIL crc_good got %b expected 0", crc96); end
        checks++; if (done_edge != 104) begin errors++; $display("FAIL crc_done_edge got %0d expected 104", done_edge); end
        words[6] = words[6] ^ 16'h0001;
        run(1'b1, -1, -1, 0, -1, 400);
        checks++; if (crc96 !== 1'b1) begin errors++; $display("FAIL crc_bad got %b expected 1", crc96); end
        checks++; if (done_edge != 104) begin errors++; $display("FAIL crc_bad_done_edge got %0d expected 104", done_edge); end
    endtask
`endif

    initial begin
        reset = 1'b0; start = 1'b0; sel = 1'b0;
        drv_data = '0; drv_valid = 1'b0;
        for (int i = 0; i < 8; i++) words[i] = '0;
        test_reset;
        test_full_load;
        test_partial_word;
        test_back_pressure;
        test_start_ignored_and_restart;
        test_reset_mid_load;
`ifdef CFG_LOADER_CRC_EN
        test_crc;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
